clk_enable_gen: RTL and testbench

//  Multi-channel fractional clock-enable generator. One phase accumulator (NCO) per channel

---
 rtl/clkgen_pkg.sv | 24 ++
 rtl/nco_channel.sv | 69 ++++++
 rtl/clk_enable_gen.sv | 75 +++++++
 tb/tb_clk_enable_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// ----------------------------------------------------------------------------
// clkgen_pkg
// Shared constants and helpers for the fractional clock-enable generator.
//   ACC_W_DEF    default phase accumulator width
//   CH_IDX_W     width of the channel index on the write port
//   freq_to_inc  phase increment for a target output frequency, rounded to
//                nearest; intended for building INC_DEFAULT at elaboration.
// ----------------------------------------------------------------------------
package clkgen_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int CH_IDX_W  = 3;

    // inc = round(f_out * 2^acc_w / f_ref). 64-bit intermediate is enough for
    // acc_w <= 32 with frequencies below 2^31 Hz.
    function automatic logic [63:0] freq_to_inc(input logic [63:0] f_ref_hz,
                                                input logic [63:0] f_out_hz,
                                                input int unsigned acc_w);
        logic [63:0] num;
        num = (f_out_hz << acc_w) + (f_ref_hz >> 1);
        return num / f_ref_hz;
    endfunction

endpackage

// File: rtl/nco_channel.sv
// ----------------------------------------------------------------------------
// nco_channel
// One phase-accumulator channel: acc advances by inc_act every cycle, the
// carry out becomes the enable pulse and the new MSB becomes the square wave.
// A written increment is held pending and only becomes active on a carry edge
// (or at once if the channel is stopped), so retuning never shortens a period.
// Ports:
//   refclk    in   system clock
//   rst_n     in   synchronous active-low reset
//   wr_en     in   write strobe, already decoded for this channel
//   wr_inc    in   new increment
//   ce        out  registered carry, one cycle per output period
//   sq        out  registered accumulator MSB
//   commit    out  pending increment is being applied on this edge
//   pend_vld  out  an increment is waiting to be applied
// ----------------------------------------------------------------------------
module nco_channel
    import clkgen_pkg::*;
#(
    parameter int               ACC_W   = ACC_W_DEF,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [ACC_W-1:0] wr_inc,
    output logic             ce,
    output logic             sq,
    output logic             commit,
    output logic             pend_vld
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_act;
    logic [ACC_W-1:0] pend;
    logic [ACC_W:0]   sum;
    logic             carry;

    assign sum    = {1'b0, acc} + {1'b0, inc_act};
    assign carry  = sum[ACC_W];
    // A stopped channel never carries, so it takes the new value straight away.
    assign commit = pend_vld && (carry || (inc_act == '0));

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            acc      <= '0;
            inc_act  <= INC_RST;
            pend     <= '0;
            pend_vld <= 1'b0;
            ce       <= 1'b0;
            sq       <= 1'b0;
        end else begin
            acc <= sum[ACC_W-1:0];
            ce  <= carry;
            sq  <= sum[ACC_W-1];
            if (commit) begin
                inc_act  <= pend;
                pend_vld <= 1'b0;
            end
            // Placed after the commit so a colliding write stays pending; the
            // commit above still sees the old pend value.
            if (wr_en) begin
                pend     <= wr_inc;
                pend_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_enable_gen.sv
// ----------------------------------------------------------------------------
// clk_enable_gen
// Multi-channel fractional clock-enable generator. Each channel is an NCO
// producing an enable pulse train and a near-50% square wave on refclk.
// 'locked' rises once no increment is pending and LOCK_CYCLES cycles have
// passed since reset or the last commit on any channel.
// Ports:
//   refclk   in   system clock
//   rst_n    in   synchronous active-low reset
//   wr_en    in   increment write strobe
//   wr_ch    in   target channel; values >= NUM_CH are ignored
//   wr_inc   in   new phase increment
//   ce       out  per-channel enable pulses
//   sq       out  per-channel square waves
//   locked   out  all channels settled on committed increments
// ----------------------------------------------------------------------------
module clk_enable_gen
    import clkgen_pkg::*;
#(
    parameter int                      NUM_CH      = 2,
    parameter int                      ACC_W       = ACC_W_DEF,
    parameter logic [NUM_CH*ACC_W-1:0] INC_DEFAULT = '0,
    parameter int                      LOCK_CYCLES = 16
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [CH_IDX_W-1:0] wr_ch,
    input  logic [ACC_W-1:0]    wr_inc,
    output logic [NUM_CH-1:0]   ce,
    output logic [NUM_CH-1:0]   sq,
    output logic                locked
);

    localparam int             CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] commit;
    logic [NUM_CH-1:0] pend_vld;
    logic [CNT_W-1:0]  lock_cnt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Only indices below NUM_CH can match, so out-of-range writes fall away.
        assign wr_sel[i] = wr_en && (wr_ch == CH_IDX_W'(i));

        nco_channel #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_DEFAULT[i*ACC_W +: ACC_W])
        ) u_ch (
            .refclk   (refclk),
            .rst_n    (rst_n),
            .wr_en    (wr_sel[i]),
            .wr_inc   (wr_inc),
            .ce       (ce[i]),
            .sq       (sq[i]),
            .commit   (commit[i]),
            .pend_vld (pend_vld[i])
        );
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            if (|commit)
                lock_cnt <= '0;
            else if (lock_cnt != LOCK_MAX)
                lock_cnt <= lock_cnt + CNT_W'(1);
            locked <= (lock_cnt == LOCK_MAX) && !(|pend_vld);
        end
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// ----------------------------------------------------------------------------
// tb_clk_enable_gen
// Directed bench for clk_enable_gen. Main instance: ACC_W=8, NUM_CH=2,
// LOCK_CYCLES=4, ch0=64 and ch1=32 at reset. A second 32-bit single-channel
// instance checks long-run frequency accuracy. Edges are numbered from the
// first rising edge after rst_n is released; samples are taken 1 ns after it.
// ----------------------------------------------------------------------------
module tb_clk_enable_gen;
    import clkgen_pkg::*;

    localparam logic [31:0] INC_HI = 32'(freq_to_inc(64'd50_000_000, 64'd18_432_000, 32));

    logic        refclk;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [7:0]  wr_inc;
    logic [1:0]  ce;
    logic [1:0]  sq;
    logic        locked;

    logic        wr_en2;
    logic [2:0]  wr_ch2;
    logic [31:0] wr_inc2;
    logic [0:0]  ce2;
    logic [0:0]  sq2;
    logic        locked2;

    int          n_checks;
    int          n_pass;
    int          edge_n;
    int          cnt;
    logic [31:0] cap_ce0, cap_ce1, cap_sq0, cap_lk;

    clk_enable_gen #(
        .NUM_CH      (2),
        .ACC_W       (8),
        .INC_DEFAULT ({8'd32, 8'd64}),
        .LOCK_CYCLES (4)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_inc (wr_inc),
        .ce     (ce),
        .sq     (sq),
        .locked (locked)
    );

    clk_enable_gen #(
        .NUM_CH      (1),
        .ACC_W       (32),
        .INC_DEFAULT (INC_HI),
        .LOCK_CYCLES (16)
    ) dut_hi (
        .refclk (refclk),
        .rst_n  (rst_n),
        .wr_en  (wr_en2),
        .wr_ch  (wr_ch2),
        .wr_inc (wr_inc2),
        .ce     (ce2),
        .sq     (sq2),
        .locked (locked2)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    task automatic step();
        @(posedge refclk);
        #1;
        edge_n++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    task automatic wr(input logic [2:0] ch, input logic [7:0] val);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_inc = val;
        step();
        wr_en  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Record n edges; optionally present a write so that edge wr_at samples it.
    task automatic cap(input int n, input int wr_at, input logic [2:0] ch, input logic [7:0] val);
        cap_ce0 = '0;
        cap_ce1 = '0;
        cap_sq0 = '0;
        cap_lk  = '0;
        for (int i = 0; i < n; i++) begin
            if (edge_n + 1 == wr_at) begin
                wr_en  = 1'b1;
                wr_ch  = ch;
                wr_inc = val;
            end
            step();
            wr_en      = 1'b0;
            cap_ce0[i] = ce[0];
            cap_ce1[i] = ce[1];
            cap_sq0[i] = sq[0];
            cap_lk[i]  = locked;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        edge_n   = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_ch    = '0;
        wr_inc   = '0;
        wr_en2   = 1'b0;
        wr_ch2   = '0;
        wr_inc2  = '0;

        // 1: reset values and default increments
        do_reset();
        chk("rst_ce", 32'(ce), 32'h0);
        chk("rst_sq", 32'(sq), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        cap(12, 0, 3'd0, 8'd0);
        chk("dflt_ce0", cap_ce0, 32'h888);
        chk("dflt_ce1", cap_ce1, 32'h080);
        chk("dflt_sq0", cap_sq0, 32'h666);
        chk("dflt_locked", cap_lk, 32'hFF0);

        // 2: retune ch0 64->128 while acc=128 (write sampled at edge 10)
        do_reset();
        tick(8);
        cap(12, 10, 3'd0, 8'd128);
        chk("retune_ce0", cap_ce0, 32'hAA8);
        chk("retune_locked", cap_lk, 32'hF03);

        // 3: zero increment, restart, then near-full increment
        do_reset();
        wr(3'd0, 8'd0);
        tick(3);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (ce[0]) cnt++;
        end
        chk("zero_no_ce", 32'(cnt), 32'd0);
        chk("zero_sq_hold", 32'(sq[0]), 32'd0);
        cap(8, edge_n + 1, 3'd0, 8'd64);
        chk("restart_ce0", cap_ce0 & 32'hFF, 32'h20);
        chk("restart_locked", cap_lk & 32'hFF, 32'hC1);
        wr(3'd0, 8'd255);
        tick(8);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (ce[0]) cnt++;
        end
        chk("full_inc_ce", 32'(cnt), 32'd255);

        // 4: write colliding with a commit on ch1, then out-of-range channel
        do_reset();
        wr(3'd1, 8'd64);
        tick(6);
        cap(12, 8, 3'd1, 8'd16);
        chk("collide_ce1", cap_ce1, 32'h011);
        chk("collide_ce0", cap_ce0, 32'h111);
        chk("collide_locked", cap_lk, 32'hE00);
        cap(12, edge_n + 1, 3'd5, 8'd1);
        chk("badch_locked", cap_lk, 32'hFFF);
        chk("badch_ce0", cap_ce0, 32'h111);
        chk("badch_ce1", cap_ce1, 32'h100);

        // 5: reset mid-operation with a write pending on ch0
        do_reset();
        wr(3'd0, 8'd128);
        tick(1);
        chk("pre_rst_sq0", 32'(sq[0]), 32'd1);
        rst_n = 1'b0;
        step();
        chk("midrst_ce", 32'(ce), 32'h0);
        chk("midrst_sq", 32'(sq), 32'h0);
        chk("midrst_locked", 32'(locked), 32'h0);
        rst_n  = 1'b1;
        edge_n = 0;
        cap(12, 0, 3'd0, 8'd0);
        chk("midrst_ce0", cap_ce0, 32'h888);
        chk("midrst_sq0", cap_sq0, 32'h666);
        chk("midrst_locked_seq", cap_lk, 32'hFF0);

        // 6: long-run accuracy, 50 MHz -> 18.432 MHz over 50000 cycles
        do_reset();
        cnt = 0;
        for (int i = 0; i < 50000; i++) begin
            step();
            if (ce2[0]) cnt++;
        end
        n_checks++;
        assert (cnt >= 18431 && cnt <= 18433) n_pass++;
        else $error("FAIL accuracy_ce_count: observed %0d expected 18432 +/- 1", cnt);
        chk("hi_locked", 32'(locked2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
